// File: rtl/l4_route_seq_pkg.sv
// Shared codes for the route sequencer: decoder selects, cell commands, status bits, FSM states.
// No logic here; widths of parametric buses live in the interface.
// Imported by l4_route_seq and its bench.
package l4_route_seq_pkg;

    typedef enum logic [2:0] {
        RS_NONE   = 3'b000,
        RS_SINGLE = 3'b001,
        RS_RANGE  = 3'b010,
        RS_ALL    = 3'b011
    } range_sel_e;

    typedef enum logic [1:0] {
        CC_NOP   = 2'b00,
        CC_CLEAR = 2'b01,
        CC_WRITE = 2'b10,
        CC_STEP  = 2'b11
    } cell_cmd_e;

    localparam int ST_FOUND   = 0;
    localparam int ST_BLOCKED = 1;
    localparam int ST_TRACED  = 2;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CLEAR    = 4'd1,
        S_MARK_SRC = 4'd2,
        S_MARK_DST = 4'd3,
        S_EXPAND   = 4'd4,
        S_SETTLE   = 4'd5,
        S_TRACE    = 4'd6,
        S_TSETTLE  = 4'd7,
        S_ETCH     = 4'd8,
        S_FINISH   = 4'd9
    } state_e;

    // Decoder plus array latency seen after every STEP command.
    localparam int SETTLE_CYC = 2;
    localparam int TMR_W      = 2;

    typedef struct packed {
        cell_cmd_e  cell_cmd;
        logic [3:0] status_in;
        logic       ret2ue;
        logic       extend;
        logic       etch_enb;
        logic       top_l;
    } arr_ctl_t;

endpackage

// File: rtl/l4_route_seq_if.sv
// Request, array-status and decoder/array control bundle for the route sequencer.
// master = requester/array side, slave = sequencer side.
// No flow control: start is a one-cycle request, busy/done report progress.
interface l4_route_seq_if #(
    parameter int NRBITS = 5,
    parameter int NCBITS = 5,
    parameter int NSBITS = 10
);
    logic              start;
    logic [NRBITS-1:0] src_row;
    logic [NRBITS-1:0] dst_row;
    logic [NCBITS-1:0] src_col;
    logic [NCBITS-1:0] dst_col;
    logic [3:0]        arr_status;

    logic [2:0]        row_range_sel;
    logic [2:0]        col_range_sel;
    logic [NRBITS-1:0] row_l_v;
    logic [NRBITS-1:0] row_u_v;
    logic [NCBITS-1:0] col_l_v;
    logic [NCBITS-1:0] col_u_v;
    logic [1:0]        cell_cmd;
    logic [3:0]        status_in;
    logic              ret2ue;
    logic              extend;
    logic              etch_enb;
    logic              top_l;
    logic              busy;
    logic              done;
    logic              success;
    logic [NSBITS-1:0] steps;

    modport master (
        output start, src_row, dst_row, src_col, dst_col, arr_status,
        input  row_range_sel, col_range_sel, row_l_v, row_u_v, col_l_v, col_u_v,
        input  cell_cmd, status_in, ret2ue, extend, etch_enb, top_l,
        input  busy, done, success, steps
    );

    modport slave (
        input  start, src_row, dst_row, src_col, dst_col, arr_status,
        output row_range_sel, col_range_sel, row_l_v, row_u_v, col_l_v, col_u_v,
        output cell_cmd, status_in, ret2ue, extend, etch_enb, top_l,
        output busy, done, success, steps
    );
endinterface

// File: rtl/l4_settle_timer.sv
// Down-counter that holds the FSM in a settle state until the array output is stable.
// Latency: expire rises load_val count cycles after load.
// No backpressure; count is ignored once expired.
module l4_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         expire
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);
endmodule

// File: rtl/l4_route_seq.sv
// Maze-routing sequencer: clear, mark endpoints, expand/settle until FOUND, trace back, etch.
// Latency: all outputs registered, aligned with the state they belong to; settle states last 2 cycles.
// No backpressure: start is only honoured in IDLE. L4_ROUTE_TIMEOUT_EN aborts expansion at saturated steps.
module l4_route_seq
    import l4_route_seq_pkg::*;
#(
    parameter int NRBITS = 5,
    parameter int NCBITS = 5,
    parameter int NSBITS = 10
) (
    input  logic          clk,
    input  logic          reset,
    l4_route_seq_if.slave bus
);
    state_e            state_q, state_d;
    logic [NRBITS-1:0] src_row_q, dst_row_q;
    logic [NCBITS-1:0] src_col_q, dst_col_q;

    range_sel_e        row_sel_q, row_sel_d, col_sel_q, col_sel_d;
    logic [NRBITS-1:0] row_l_q, row_l_d, row_u_q, row_u_d;
    logic [NCBITS-1:0] col_l_q, col_l_d, col_u_q, col_u_d;
    arr_ctl_t          ctl_q, ctl_d;
    logic              busy_q, busy_d, done_q, done_d, success_q, success_d;
    logic [NSBITS-1:0] steps_q, steps_d;

    logic accept, tmr_load, tmr_count, tmr_expire;
    logic found, blocked, traced;

    assign accept  = (state_q == S_IDLE) && bus.start;
    assign found   = bus.arr_status[ST_FOUND];
    assign blocked = bus.arr_status[ST_BLOCKED];
    assign traced  = bus.arr_status[ST_TRACED];

    l4_settle_timer #(.W(TMR_W)) u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TMR_W'(SETTLE_CYC - 1)),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        steps_d   = steps_q;
        success_d = success_q;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_CLEAR;
                    steps_d   = '0;
                    success_d = 1'b0;
                end
            end
            S_CLEAR:    state_d = S_MARK_SRC;
            S_MARK_SRC: state_d = S_MARK_DST;
            S_MARK_DST: state_d = S_EXPAND;
            S_EXPAND: begin
                steps_d  = (&steps_q) ? steps_q : steps_q + NSBITS'(1);
                tmr_load = 1'b1;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                tmr_count = 1'b1;
                // FOUND wins over BLOCKED: a wavefront that reached dst is routable.
                if (tmr_expire) begin
                    if (found) begin
                        state_d = S_TRACE;
                    end else if (blocked) begin
                        state_d = S_FINISH;
                    end
`ifdef L4_ROUTE_TIMEOUT_EN
                    else if (&steps_q) begin
                        state_d = S_FINISH;
                    end
`endif
                    else begin
                        state_d = S_EXPAND;
                    end
                end
            end
            S_TRACE: begin
                tmr_load = 1'b1;
                state_d  = S_TSETTLE;
            end
            S_TSETTLE: begin
                tmr_count = 1'b1;
                if (tmr_expire) begin
                    state_d = traced ? S_ETCH : S_TRACE;
                end
            end
            S_ETCH: begin
                success_d = 1'b1;
                state_d   = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registers line up with state_q.
        row_sel_d = RS_NONE;
        col_sel_d = RS_NONE;
        row_l_d   = '0;
        row_u_d   = '0;
        col_l_d   = '0;
        col_u_d   = '0;
        ctl_d     = '0;
        done_d    = 1'b0;
        busy_d    = (state_d != S_IDLE) && (state_d != S_FINISH);
        case (state_d)
            S_CLEAR: begin
                row_sel_d      = RS_ALL;
                col_sel_d      = RS_ALL;
                ctl_d.cell_cmd = CC_CLEAR;
            end
            S_MARK_SRC, S_MARK_DST: begin
                row_sel_d       = RS_SINGLE;
                col_sel_d       = RS_SINGLE;
                row_l_d         = (state_d == S_MARK_SRC) ? src_row_q : dst_row_q;
                col_l_d         = (state_d == S_MARK_SRC) ? src_col_q : dst_col_q;
                row_u_d         = row_l_d;
                col_u_d         = col_l_d;
                ctl_d.cell_cmd  = CC_WRITE;
                ctl_d.status_in = (state_d == S_MARK_SRC) ? 4'h1 : 4'h2;
            end
            S_EXPAND: begin
                row_sel_d      = RS_ALL;
                col_sel_d      = RS_ALL;
                ctl_d.cell_cmd = CC_STEP;
                ctl_d.extend   = 1'b1;
            end
            S_TRACE: begin
                row_sel_d      = RS_ALL;
                col_sel_d      = RS_ALL;
                ctl_d.cell_cmd = CC_STEP;
                ctl_d.ret2ue   = 1'b1;
                ctl_d.top_l    = 1'b1;
            end
            S_TSETTLE: ctl_d.top_l = 1'b1;
            S_ETCH: begin
                row_sel_d      = RS_ALL;
                col_sel_d      = RS_ALL;
                ctl_d.etch_enb = 1'b1;
            end
            S_FINISH: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row_sel_q <= RS_NONE;
            col_sel_q <= RS_NONE;
            row_l_q   <= '0;
            row_u_q   <= '0;
            col_l_q   <= '0;
            col_u_q   <= '0;
            ctl_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            success_q <= 1'b0;
            steps_q   <= '0;
        end else begin
            state_q   <= state_d;
            row_sel_q <= row_sel_d;
            col_sel_q <= col_sel_d;
            row_l_q   <= row_l_d;
            row_u_q   <= row_u_d;
            col_l_q   <= col_l_d;
            col_u_q   <= col_u_d;
            ctl_q     <= ctl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            success_q <= success_d;
            steps_q   <= steps_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_row_q <= '0;
            src_col_q <= '0;
            dst_row_q <= '0;
            dst_col_q <= '0;
        end else if (accept) begin
            src_row_q <= bus.src_row;
            src_col_q <= bus.src_col;
            dst_row_q <= bus.dst_row;
            dst_col_q <= bus.dst_col;
        end
    end

    assign bus.row_range_sel = row_sel_q;
    assign bus.col_range_sel = col_sel_q;
    assign bus.row_l_v       = row_l_q;
    assign bus.row_u_v       = row_u_q;
    assign bus.col_l_v       = col_l_q;
    assign bus.col_u_v       = col_u_q;
    assign bus.cell_cmd      = ctl_q.cell_cmd;
    assign bus.status_in     = ctl_q.status_in;
    assign bus.ret2ue        = ctl_q.ret2ue;
    assign bus.extend        = ctl_q.extend;
    assign bus.etch_enb      = ctl_q.etch_enb;
    assign bus.top_l         = ctl_q.top_l;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.success       = success_q;
    assign bus.steps         = steps_q;
endmodule
